count_sequence_checker: RTL and testbench

//   Downstream monitor for the free-running sync counter. Samples the counter's count output every

---
 rtl/count_sequence_checker.sv | 122 ++++++++++++
 tb/tb_count_sequence_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - sequence monitor for a free-running modulo counter
//
// Purpose:
//   Samples count_in on every cycle where in_valid is high. It checks that the value
//   advances by exactly +1 modulo (MAX_VAL+1). It pulses wrap_pulse on each MAX_VAL->0 step
//   and keeps a saturating wrap tally. A skip, stall or backstep sets a sticky error.
//
// Ports:
//   clk          in   rising-edge clock (same clock as the monitored counter)
//   reset        in   asynchronous, active-high; clears all state
//   in_valid     in   1 = sample count_in this cycle, 0 = hold all state
//   count_in     in   [WIDTH-1:0] counter value under test
//   err_clr      in   level; in ERR clears err_flag/wrap_count and resynchronises
//   locked       out  1 while tracking the sequence
//   wrap_pulse   out  one-cycle registered pulse per detected wrap
//   wrap_count   out  [WRAP_W-1:0] saturating wrap tally
//   err_flag     out  sticky sequence-error flag
//   err_expected out  [WIDTH-1:0] expected value at the failing sample (SEQ_CHK_CAPTURE_EN only)
//   err_actual   out  [WIDTH-1:0] observed value at the failing sample (SEQ_CHK_CAPTURE_EN only)
//
// Configuration macro: SEQ_CHK_CAPTURE_EN (adds the error-capture ports)

module count_sequence_checker #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              err_clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err_flag
`ifdef SEQ_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]  err_expected,
    output logic [WIDTH-1:0]  err_actual
`endif
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [1:0]       state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_val;
    logic             at_max;

    // Values above MAX_VAL can never equal exp_val, so they fail the check automatically.
    always_comb begin
        at_max  = (prev == MAX_V);
        exp_val = at_max ? '0 : prev + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_SYNC;
            prev         <= '0;
            locked       <= 1'b0;
            wrap_pulse   <= 1'b0;
            wrap_count   <= '0;
            err_flag     <= 1'b0;
`ifdef SEQ_CHK_CAPTURE_EN
            err_expected <= '0;
            err_actual   <= '0;
`endif
        end else begin
            // The pulse is only re-armed by a wrap sample, so it can never stretch
            // across back-to-back samples or idle cycles.
            wrap_pulse <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (in_valid) begin
                        prev   <= count_in;
                        locked <= 1'b1;
                        state  <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (in_valid) begin
                        if (count_in == exp_val) begin
                            prev <= count_in;
                            if (at_max) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_count != '1) begin
                                    wrap_count <= wrap_count + 1'b1;
                                end
                            end
                        end else begin
                            err_flag     <= 1'b1;
                            locked       <= 1'b0;
                            state        <= ST_ERR;
`ifdef SEQ_CHK_CAPTURE_EN
                            err_expected <= exp_val;
                            err_actual   <= count_in;
`endif
                        end
                    end
                end
                ST_ERR: begin
                    // prev stays frozen here; SYNC reloads it from the next valid sample.
                    if (err_clr) begin
                        err_flag   <= 1'b0;
                        wrap_count <= '0;
                        state      <= ST_SYNC;
                    end
                end
                default: begin
                    locked <= 1'b0;
                    state  <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed self-checking bench for count_sequence_checker

module tb_count_sequence_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] count_in;
    logic       err_clr;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       err_flag;
`ifdef SEQ_CHK_CAPTURE_EN
    logic [3:0] err_expected;
    logic [3:0] err_actual;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    count_sequence_checker #(.WIDTH(4), .MAX_VAL(15), .WRAP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .count_in   (count_in),
        .err_clr    (err_clr),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .err_flag   (err_flag)
`ifdef SEQ_CHK_CAPTURE_EN
        ,
        .err_expected (err_expected),
        .err_actual   (err_actual)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 ns after the active edge.
    task automatic step(input logic v, input logic [3:0] c);
        in_valid = v;
        count_in = c;
        @(posedge clk);
        #1;
        if (wrap_pulse === 1'b1) pulses++;
    endtask

    task automatic outs(input string tag, input logic lk, input logic wp,
                        input logic [7:0] wc, input logic ef);
        check({tag, ".locked"},     locked,     lk);
        check({tag, ".wrap_pulse"}, wrap_pulse, wp);
        check({tag, ".wrap_count"}, wrap_count, wc);
        check({tag, ".err_flag"},   err_flag,   ef);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        count_in = 4'd0;
        err_clr  = 1'b0;
        #3;
        outs("reset", 1'b0, 1'b0, 8'd0, 1'b0);
        #9;
        reset = 1'b0;

        // 1: clean count 0..15,0,1
        step(1'b1, 4'd0);
        outs("t1_first", 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 15; i++) step(1'b1, 4'(i));
        check("t1_no_pulse_before_wrap", wrap_pulse, 1'b0);
        step(1'b1, 4'd0);
        outs("t1_wrap", 1'b1, 1'b1, 8'd1, 1'b0);
        step(1'b1, 4'd1);
        outs("t1_after_wrap", 1'b1, 1'b0, 8'd1, 1'b0);

        // 2: skip 3,4,6
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd4);
        step(1'b1, 4'd6);
        outs("t2_skip", 1'b0, 1'b0, 8'd1, 1'b0 | 1'b1);
`ifdef SEQ_CHK_CAPTURE_EN
        check("t2_err_expected", err_expected, 4'd5);
        check("t2_err_actual",   err_actual,   4'd6);
`endif
        step(1'b1, 4'd7);
        outs("t2_in_err", 1'b0, 1'b0, 8'd1, 1'b1);
        err_clr = 1'b1;
        step(1'b0, 4'd0);
        err_clr = 1'b0;
        outs("t2_clr", 1'b0, 1'b0, 8'd0, 1'b0);

        // 3: stall 7,7 then err_clr and resync
        step(1'b1, 4'd7);
        check("t3_sync_locked", locked, 1'b1);
        step(1'b1, 4'd7);
        outs("t3_stall", 1'b0, 1'b0, 8'd0, 1'b1);
        err_clr = 1'b1;
        step(1'b0, 4'd3);
        err_clr = 1'b0;
        outs("t3_clr", 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b1, 4'd7);
        outs("t3_resync", 1'b1, 1'b0, 8'd0, 1'b0);

        // 4: idle cycles with arbitrary count_in
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'($urandom_range(0, 15)));
            outs("t4_idle", 1'b1, 1'b0, 8'd0, 1'b0);
        end
        step(1'b1, 4'd8);
        outs("t4_resume", 1'b1, 1'b0, 8'd0, 1'b0);

        // 5: 300 wraps, tally saturates at 255
        for (int i = 9; i <= 15; i++) step(1'b1, 4'(i));
        pulses = 0;
        for (int i = 0; i < 300 * 16; i++) step(1'b1, 4'(i % 16));
        check("t5_pulse_count", pulses, 300);
        outs("t5_saturated", 1'b1, 1'b0, 8'd255, 1'b0);

        // 6: reset mid-run at count 9, including a live wrap pulse dropped earlier
        step(1'b1, 4'd0);
        check("t6_wrap_pulse_live", wrap_pulse, 1'b1);
        for (int i = 1; i <= 9; i++) step(1'b1, 4'(i));
        #2;
        reset = 1'b1;
        #1;
        outs("t6_reset", 1'b0, 1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 4'd12);
        outs("t6_first_after_reset", 1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b1, 4'd13);
        outs("t6_track", 1'b1, 1'b0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
